pipe_reg_skid: RTL and testbench
================================

# pipe_reg_skid

Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer, the successor to our plain 32-bit enable register. Sits between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces the bare En-controlled register. Adds back-pressure without a combinational ready path, a synchronous flush for branch/exception squash, and a saturating stall-cycle counter for performance monitoring.

## Interface
- WIDTH, 32: payload width in bits.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into both data registers on reset and on flush.
- CNT_W, 16: stall counter width.

- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- Flush  in  1  synchronous squash; empties the stage.
- Entrada  in  WIDTH  upstream payload.
- In_Valid  in  1  upstream payload valid.
- In_Ready  out  1  stage can accept; registered.
- Saida  out  WIDTH  downstream payload.
- Out_Valid  out  1  Saida valid; registered.
- Out_Ready  in  1  downstream accepts.
- Stall_Count  out  CNT_W  saturating count of stalled cycles.

## Operation
- Transfers: in-accept = In_Valid & In_Ready; out-accept = Out_Valid & Out_Ready.
- Registers: main (drives Saida), skid, 2-bit state, Stall_Count.
- EMPTY: In_Ready=1, Out_Valid=0. in-accept -> main<=Entrada, BUSY.
- BUSY: In_Ready=1, Out_Valid=1.
  - in & out accept -> main<=Entrada, stay BUSY.
  - in only -> skid<=Entrada, FULL.
  - out only -> EMPTY.
  - neither -> hold.
- FULL: In_Ready=0, Out_Valid=1. out-accept -> main<=skid, BUSY; otherwise hold.
- Flush: highest synchronous priority. state<=EMPTY, main<=RESET_VALUE, skid<=RESET_VALUE. An input transfer in the same cycle is discarded; upstream treats it as consumed. An output transfer in the same cycle completes normally.
- Stall_Count: +1 each cycle with Out_Valid & ~Out_Ready, including cycles with Flush asserted. Saturates at 2^CNT_W-1, never wraps. Cleared only by Rst.
- Data ordering: strict FIFO. The skid entry is always older than any later input.
- The FULL-state In_Ready=0 is itself the back-pressure. No payload is lost or duplicated under any In_Valid/Out_Ready pattern.

## Timing
- Latency: Entrada accepted at edge N appears on Saida with Out_Valid=1 after edge N, when the stage was EMPTY or main was drained at edge N.
- Throughput: 1 transfer/cycle while Out_Ready=1.
- In_Ready and Out_Valid are decoded purely from the state register. There is no combinational path from Out_Ready or In_Valid to any output.
- Saida comes directly from the main register. There is no combinational path from Entrada.
- Reset values, asserted immediately on Rst, independent of Clk:
  - state=EMPTY
  - Saida=RESET_VALUE
  - skid=RESET_VALUE
  - Out_Valid=0
  - In_Ready=1
  - Stall_Count=0
- Rst mid-operation drops both entries without completing any handshake.
- State encoding 2'b11 is illegal and decodes as EMPTY on the next edge.

## Structure
- Package pipe_reg_pkg:
  - state typedef: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10.
  - shared default WIDTH/CNT_W constants.
- Sub-module en_reg: parametrised WIDTH enable register with async reset to RESET_VALUE and a synchronous clear. Instantiated twice, for main and skid.
- State logic, handshake decode and stall counter live in the top module.

## Test plan
- Reset with In_Valid=1, Entrada=32'hDEADBEEF -> Saida=0, Out_Valid=0, In_Ready=1. First edge after release -> Saida=32'hDEADBEEF, Out_Valid=1.
- Streaming with Out_Ready=1, inputs 1,2,3,4 on consecutive cycles -> Saida shows 1,2,3,4 on consecutive cycles, one-cycle latency, In_Ready stays 1.
- Out_Ready=0 while sending A then B -> state FULL, In_Ready=0, Saida=A, C held off by upstream. Out_Ready=1 -> A, B, C delivered in order with no loss.
- Flush in FULL, with In_Valid=1 carrying X -> next cycle Out_Valid=0, Saida=RESET_VALUE, state EMPTY, X never appears.
- CNT_W=4, Out_Valid=1 and Out_Ready=0 for 20 cycles -> Stall_Count reaches 15 and stays there. Flush leaves it unchanged; Rst clears it to 0.
- Random In_Valid/Out_Ready, 10k cycles, scoreboard -> output sequence equals accepted input sequence minus flushed entries, with no In_Ready/Out_Ready combinational dependency.

Source files
------------

// File: rtl/pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_reg_pkg
// Shared types and defaults for the skid-buffered pipeline stage register.
//   state_t        : handshake state (EMPTY / BUSY / FULL); 2'b11 is unused
//   DEFAULT_WIDTH  : default payload width
//   DEFAULT_CNT_W  : default stall-counter width
// ---------------------------------------------------------------------------
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,   // no entry held
        BUSY  = 2'b01,   // main holds the only entry
        FULL  = 2'b10    // main holds the older entry, skid the younger
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/en_reg.sv
// ---------------------------------------------------------------------------
// en_reg
// Enable register with asynchronous reset and synchronous clear.
//   Clk  in  clock
//   Rst  in  asynchronous active-high reset, loads RESET_VALUE
//   Clr  in  synchronous clear, loads RESET_VALUE (wins over En)
//   En   in  load enable
//   D    in  WIDTH data in
//   Q    out WIDTH registered data out
// ---------------------------------------------------------------------------
module en_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clr,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Q <= RESET_VALUE;
        end else if (Clr) begin
            Q <= RESET_VALUE;
        end else if (En) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// ---------------------------------------------------------------------------
// pipe_reg_skid
// Pipeline-stage register with valid/ready handshake and a one-entry skid
// buffer. In_Ready and Out_Valid are decoded from the state register only,
// and Saida comes straight from the main register, so no input reaches an
// output combinationally.
//   Clk          in  clock
//   Rst          in  asynchronous active-high reset
//   Flush        in  synchronous squash; empties the stage
//   Entrada      in  WIDTH upstream payload
//   In_Valid     in  upstream payload valid
//   In_Ready     out stage can accept
//   Saida        out WIDTH downstream payload (main register)
//   Out_Valid    out Saida valid
//   Out_Ready    in  downstream accepts
//   Stall_Count  out CNT_W saturating count of Out_Valid & ~Out_Ready cycles
// ---------------------------------------------------------------------------
module pipe_reg_skid
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W       = DEFAULT_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic [WIDTH-1:0] Entrada,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Saida,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [CNT_W-1:0] Stall_Count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic             in_acc, out_acc;

    // Handshake decode: the unused 2'b11 encoding reads as EMPTY.
    assign In_Ready  = (state != FULL);
    assign Out_Valid = (state == BUSY) || (state == FULL);

    assign in_acc  = In_Valid  & In_Ready;
    assign out_acc = Out_Valid & Out_Ready;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        main_d    = Entrada;
        skid_en   = 1'b0;

        case (state)
            BUSY: begin
                if (in_acc && out_acc) begin
                    main_en = 1'b1;
                end else if (in_acc) begin
                    // Main is stuck downstream: park the younger entry.
                    skid_en   = 1'b1;
                    state_nxt = FULL;
                end else if (out_acc) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_acc) begin
                    main_en   = 1'b1;
                    main_d    = skid_q;
                    state_nxt = BUSY;
                end
            end
            default: begin  // EMPTY and the illegal encoding
                if (in_acc) begin
                    main_en = 1'b1;
                end
                state_nxt = in_acc ? BUSY : EMPTY;
            end
        endcase

        // Flush drops any incoming entry; the data registers clear themselves
        // through their Clr port, and an output transfer this cycle still counts
        // as delivered because downstream saw Out_Valid & Out_Ready.
        if (Flush) begin
            state_nxt = EMPTY;
            main_en   = 1'b0;
            skid_en   = 1'b0;
        end
    end

    en_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
        .Clk (Clk),
        .Rst (Rst),
        .Clr (Flush),
        .En  (main_en),
        .D   (main_d),
        .Q   (Saida)
    );

    en_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
        .Clk (Clk),
        .Rst (Rst),
        .Clr (Flush),
        .En  (skid_en),
        .D   (Entrada),
        .Q   (skid_q)
    );

    // Stall counter keeps counting during Flush; only Rst clears it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Stall_Count <= '0;
        end else if (Out_Valid && !Out_Ready && (Stall_Count != CNT_MAX)) begin
            Stall_Count <= Stall_Count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg_skid
// Self-checking bench for pipe_reg_skid (WIDTH=32, CNT_W=4): directed vector
// table, stall-counter saturation and reset sequence, then a randomized run
// against a queue-based occupancy model.
// ---------------------------------------------------------------------------
module tb_pipe_reg_skid;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic              Clk;
    logic              Rst;
    logic              Flush;
    logic [31:0]       Entrada;
    logic              In_Valid;
    logic              In_Ready;
    logic [31:0]       Saida;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [CNT_W-1:0]  Stall_Count;

    int errors = 0;
    int checks = 0;

    pipe_reg_skid #(.WIDTH(32), .CNT_W(CNT_W)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Flush       (Flush),
        .Entrada     (Entrada),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .Saida       (Saida),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Stall_Count (Stall_Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the stage is a FIFO of depth two; Saida shows the
    // head, keeps its last value when drained, and is zero after reset/flush.
    logic [31:0] mq[$];
    logic [31:0] m_saida;
    int          m_cnt;

    task automatic model_reset();
        mq.delete();
        m_saida = 32'h0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        bit in_acc, out_acc;
        in_acc  = In_Valid && (mq.size() < 2);
        out_acc = (mq.size() > 0) && Out_Ready;
        if ((mq.size() > 0) && !Out_Ready && (m_cnt < CNT_MAX)) m_cnt++;
        if (out_acc) void'(mq.pop_front());
        if (Flush) begin
            mq.delete();
            m_saida = 32'h0;
        end else begin
            if (in_acc) mq.push_back(Entrada);
            if (mq.size() > 0) m_saida = mq[0];
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
        Flush     = fl;
        In_Valid  = iv;
        Entrada   = d;
        Out_Ready = ordy;
    endtask

    // One clock: apply inputs, take the edge, settle 1 time unit past it.
    task automatic step(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
        drive(fl, iv, d, ordy);
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [31:0] q;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int ready_pct;

        // Inputs for one edge, then expected outputs just after that edge.
        tbl[0]  = '{1'b0, 1'b1, 32'h1,  1'b1, 1'b1, 1'b1, 32'h1,  4'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'h2,  1'b1, 1'b1, 1'b1, 32'h2,  4'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 32'h3,  4'd0};
        tbl[3]  = '{1'b0, 1'b1, 32'h4,  1'b1, 1'b1, 1'b1, 32'h4,  4'd0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h4,  4'd0};
        tbl[5]  = '{1'b0, 1'b1, 32'hA,  1'b0, 1'b1, 1'b1, 32'hA,  4'd0};
        tbl[6]  = '{1'b0, 1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 32'hA,  4'd1};
        tbl[7]  = '{1'b0, 1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 32'hA,  4'd2};
        tbl[8]  = '{1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 1'b1, 32'hB,  4'd2};
        tbl[9]  = '{1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 1'b1, 32'hC,  4'd2};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'hC,  4'd2};
        tbl[11] = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 4'd2};
        tbl[12] = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 4'd3};
        tbl[13] = '{1'b1, 1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 32'h0,  4'd4};
        tbl[14] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  4'd4};
        tbl[15] = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 32'h33, 4'd4};
        tbl[16] = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 32'h0,  4'd4};
        tbl[17] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  4'd4};

        // ---- Reset with a valid payload waiting upstream ----
        Rst = 1'b1;
        drive(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        #2;
        check("rst_saida",     Saida,           32'h0);
        check("rst_out_valid", 32'(Out_Valid),  32'h0);
        check("rst_in_ready",  32'(In_Ready),   32'h1);
        check("rst_stall",     32'(Stall_Count), 32'h0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        check("first_saida",     Saida,          32'hDEADBEEF);
        check("first_out_valid", 32'(Out_Valid), 32'h1);
        check("first_in_ready",  32'(In_Ready),  32'h1);

        // ---- Directed table: streaming, back-pressure, flush ----
        foreach (tbl[i]) begin
            step(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check($sformatf("tbl%0d_in_ready", i),  32'(In_Ready),    32'(tbl[i].ir));
            check($sformatf("tbl%0d_out_valid", i), 32'(Out_Valid),   32'(tbl[i].ov));
            check($sformatf("tbl%0d_saida", i),     Saida,            tbl[i].q);
            check($sformatf("tbl%0d_stall", i),     32'(Stall_Count), 32'(tbl[i].cnt));
        end

        // ---- Stall counter saturation (starts at 4) ----
        step(1'b0, 1'b1, 32'h55, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("sat_mid", 32'(Stall_Count), 32'd13);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("sat_top",   32'(Stall_Count), 32'd15);
        check("sat_saida", Saida,            32'h55);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("sat_flush_cnt",   32'(Stall_Count), 32'd15);
        check("sat_flush_valid", 32'(Out_Valid),   32'h0);

        // ---- Asynchronous reset mid-operation clears the counter at once ----
        step(1'b0, 1'b1, 32'h66, 1'b0);
        #2;
        Rst = 1'b1;
        #1;
        check("async_rst_cnt",   32'(Stall_Count), 32'h0);
        check("async_rst_valid", 32'(Out_Valid),   32'h0);
        check("async_rst_saida", Saida,            32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_reset();

        // ---- Randomized traffic against the FIFO model ----
        ready_pct = 50;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ready_pct = 20;
                    1:       ready_pct = 50;
                    default: ready_pct = 90;
                endcase
            end
            drive(($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 1)),
                  $urandom,
                  ($urandom_range(0, 99) < ready_pct));
            // Inputs already changed: outputs must still reflect only state.
            #2;
            check("rnd_in_ready",  32'(In_Ready),    32'(mq.size() < 2));
            check("rnd_out_valid", 32'(Out_Valid),   32'(mq.size() > 0));
            check("rnd_saida",     Saida,            m_saida);
            check("rnd_stall",     32'(Stall_Count), 32'(m_cnt));
            @(posedge Clk);
            model_edge();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
